// File: rtl/screen_fetch_arbiter.sv
// Shares the single-port screen RAM between the CPU and a video row fetcher.
// A line_start pulse bursts one row into the line buffer, stalling the CPU for the burst only.
module screen_fetch_arbiter #(
  parameter int unsigned            ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 16'h0200,
  parameter int unsigned            ROW_BITS   = 5,
  parameter int unsigned            COL_BITS   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_start,
  input  logic [ROW_BITS-1:0]   fetch_row,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_wdata,
  output logic                  cpu_rdy,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata,
  output logic                  lb_we,
  output logic [COL_BITS-1:0]   lb_waddr,
  output logic [7:0]            lb_wdata,
  output logic                  fetch_busy,
  output logic                  fetch_done,
  output logic                  fetch_overrun
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ROW_BITS-1:0]   row_q, row_d;
  logic [COL_BITS-1:0]   col_q, col_d;
  logic                  lb_we_q;
  logic [COL_BITS-1:0]   lb_waddr_q;
  logic                  fetch_done_q;
  logic                  fetch_busy_q;
  logic                  overrun_q;

  logic [ADDR_WIDTH-1:0] vid_addr;
  logic                  col_last;

  // Offset is truncated to the address width, so the sum wraps silently.
  assign vid_addr = BASE_ADDR + ADDR_WIDTH'({row_q, col_q});
  assign col_last = (col_q == '1);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    ram_en    = cpu_req;
    ram_we    = cpu_we & cpu_req;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    cpu_rdy   = 1'b1;
    case (state_q)
      StIdle: begin
        if (line_start) begin
          row_d   = fetch_row;
          col_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        ram_en   = 1'b1;
        ram_we   = 1'b0;
        ram_addr = vid_addr;
        cpu_rdy  = 1'b0;
        col_d    = col_q + 1'b1;
        if (col_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      lb_we_q      <= 1'b0;
      lb_waddr_q   <= '0;
      fetch_done_q <= 1'b0;
      fetch_busy_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      // Read data lands one cycle after the column is issued.
      lb_we_q      <= (state_q == StFetch);
      lb_waddr_q   <= col_q;
      fetch_done_q <= (state_q == StFetch) && col_last;
      fetch_busy_q <= (state_d != StIdle);
      if (line_start && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign lb_we         = lb_we_q;
  assign lb_waddr      = lb_waddr_q;
  assign lb_wdata      = ram_rdata;
  assign fetch_busy    = fetch_busy_q;
  assign fetch_done    = fetch_done_q;
  assign fetch_overrun = overrun_q;

endmodule

// File: tb/tb_screen_fetch_arbiter.sv
// Directed bench for screen_fetch_arbiter: CPU pass-through, row bursts, stall, overrun,
// reset handling and address wrap (second instance with a high base address).
module tb_screen_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [4:0]  fetch_row;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;

  logic        cpu_rdy, ram_en, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        lb_we;
  logic [4:0]  lb_waddr;
  logic [7:0]  lb_wdata;
  logic        fetch_busy, fetch_done, fetch_overrun;

  logic        w_cpu_rdy, w_ram_en, w_ram_we;
  logic [15:0] w_ram_addr;
  logic [7:0]  w_ram_wdata, w_ram_rdata;
  logic        w_lb_we;
  logic [4:0]  w_lb_waddr;
  logic [7:0]  w_lb_wdata;
  logic        w_fetch_busy, w_fetch_done, w_fetch_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [65536];

  always #5 clk = ~clk;

  screen_fetch_arbiter #(
    .ADDR_WIDTH (16),
    .BASE_ADDR  (16'h0200),
    .ROW_BITS   (5),
    .COL_BITS   (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .line_start    (line_start),
    .fetch_row     (fetch_row),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdy       (cpu_rdy),
    .ram_en        (ram_en),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata),
    .lb_we         (lb_we),
    .lb_waddr      (lb_waddr),
    .lb_wdata      (lb_wdata),
    .fetch_busy    (fetch_busy),
    .fetch_done    (fetch_done),
    .fetch_overrun (fetch_overrun)
  );

  screen_fetch_arbiter #(
    .ADDR_WIDTH (16),
    .BASE_ADDR  (16'hFFF0),
    .ROW_BITS   (5),
    .COL_BITS   (5)
  ) dut_wrap (
    .clk           (clk),
    .reset         (reset),
    .line_start    (line_start),
    .fetch_row     (fetch_row),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdy       (w_cpu_rdy),
    .ram_en        (w_ram_en),
    .ram_we        (w_ram_we),
    .ram_addr      (w_ram_addr),
    .ram_wdata     (w_ram_wdata),
    .ram_rdata     (w_ram_rdata),
    .lb_we         (w_lb_we),
    .lb_waddr      (w_lb_waddr),
    .lb_wdata      (w_lb_wdata),
    .fetch_busy    (w_fetch_busy),
    .fetch_done    (w_fetch_done),
    .fetch_overrun (w_fetch_overrun)
  );

  // Synchronous single-port RAM, byte = addr[7:0] at start.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  always @(posedge clk) begin
    w_ram_rdata <= w_ram_addr[7:0];
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    next();
    next();
    reset = 1'b0;
    #2;
    n_checks++;
    if (fetch_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", fetch_busy);
    end
    n_checks++;
    if (lb_we !== 1'b0 || fetch_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_lb: got lb_we=%b done=%b expected 0/0", lb_we, fetch_done);
    end
    n_checks++;
    if (fetch_overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_overrun: got %b expected 0", fetch_overrun);
    end
    n_checks++;
    if (cpu_rdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_rdy: got %b expected 1", cpu_rdy);
    end
  endtask

  task automatic test_idle_cpu();
    for (int k = 0; k < 4; k++) begin
      next();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hAB;
      #2;
      n_checks++;
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || cpu_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_ctrl: got en=%b we=%b rdy=%b expected 1/1/1", ram_en, ram_we, cpu_rdy);
      end
      n_checks++;
      if (ram_addr !== 16'h0010 || ram_wdata !== 8'hAB) begin
        n_fail++;
        $display("FAIL idle_bus: got addr=%h data=%h expected 0010/ab", ram_addr, ram_wdata);
      end
    end
    next();
    cpu_req = 1'b0; cpu_we = 1'b0;
    #2;
    n_checks++;
    if (ram_en !== 1'b0 || ram_we !== 1'b0) begin
      n_fail++; $display("FAIL idle_noreq: got en=%b we=%b expected 0/0", ram_en, ram_we);
    end
  endtask

  // Full burst with a CPU read granted at T and held through the stall.
  task automatic test_row_fetch(input logic [4:0] row);
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
    int          stall;
    next();
    line_start = 1'b1; fetch_row = row;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0155;
    #2;
    n_checks++;
    if (cpu_rdy !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 16'h0155) begin
      n_fail++;
      $display("FAIL fetch_grant_T: got rdy=%b en=%b we=%b addr=%h expected 1/1/0/0155",
               cpu_rdy, ram_en, ram_we, ram_addr);
    end
    stall = 0;
    for (int k = 1; k <= 33; k++) begin
      next();
      line_start = 1'b0;
      #2;
      if (cpu_rdy === 1'b0) stall++;
      if (k == 1) begin
        n_checks++;
        if (ram_rdata !== 8'h55) begin
          n_fail++; $display("FAIL fetch_cpu_read: got %h expected 55", ram_rdata);
        end
      end
      if (k <= 32) begin
        exp_addr = 16'h0200 + 16'({row, 5'(k - 1)});
        n_checks++;
        if (ram_addr !== exp_addr || ram_en !== 1'b1 || ram_we !== 1'b0 || cpu_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL fetch_issue k=%0d: got addr=%h en=%b we=%b rdy=%b expected %h/1/0/0",
                   k, ram_addr, ram_en, ram_we, cpu_rdy, exp_addr);
        end
      end else begin
        n_checks++;
        if (cpu_rdy !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 16'h0155) begin
          n_fail++;
          $display("FAIL fetch_drain_cpu: got rdy=%b en=%b addr=%h expected 1/1/0155",
                   cpu_rdy, ram_en, ram_addr);
        end
      end
      n_checks++;
      if (lb_we !== (k >= 2)) begin
        n_fail++; $display("FAIL fetch_lb_we k=%0d: got %b expected %b", k, lb_we, (k >= 2));
      end
      if (k >= 2) begin
        exp_addr = 16'h0200 + 16'({row, 5'(k - 2)});
        exp_data = exp_addr[7:0];
        n_checks++;
        if (lb_waddr !== 5'(k - 2) || lb_wdata !== exp_data) begin
          n_fail++;
          $display("FAIL fetch_lb k=%0d: got col=%0d data=%h expected %0d/%h",
                   k, lb_waddr, lb_wdata, k - 2, exp_data);
        end
      end
      n_checks++;
      if (fetch_busy !== 1'b1 || fetch_done !== (k == 33)) begin
        n_fail++;
        $display("FAIL fetch_flags k=%0d: got busy=%b done=%b expected 1/%b",
                 k, fetch_busy, fetch_done, (k == 33));
      end
    end
    n_checks++;
    if (stall != 32) begin
      n_fail++; $display("FAIL fetch_stall_len: got %0d expected 32", stall);
    end
    next();
    cpu_req = 1'b0;
    #2;
    n_checks++;
    if (fetch_busy !== 1'b0 || lb_we !== 1'b0 || fetch_done !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_after: got busy=%b lb_we=%b done=%b expected 0/0/0",
               fetch_busy, lb_we, fetch_done);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] exp_addr;
    next();
    line_start = 1'b1; fetch_row = 5'd3;
    for (int k = 1; k <= 33; k++) begin
      next();
      line_start = (k == 10);
      fetch_row  = (k == 10) ? 5'd7 : 5'd3;
      #2;
      n_checks++;
      if (fetch_overrun !== (k >= 11)) begin
        n_fail++;
        $display("FAIL ovr_flag k=%0d: got %b expected %b", k, fetch_overrun, (k >= 11));
      end
      if (k <= 32 && k >= 9) begin
        exp_addr = 16'h0260 + 16'(k - 1);
        n_checks++;
        if (ram_addr !== exp_addr) begin
          n_fail++; $display("FAIL ovr_addr k=%0d: got %h expected %h", k, ram_addr, exp_addr);
        end
      end
      if (k >= 31) begin
        n_checks++;
        if (fetch_done !== (k == 33)) begin
          n_fail++; $display("FAIL ovr_done k=%0d: got %b expected %b", k, fetch_done, (k == 33));
        end
      end
    end
    next();
    line_start = 1'b0;
    #2;
    n_checks++;
    if (fetch_busy !== 1'b0 || fetch_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_hold: got busy=%b ovr=%b expected 0/1", fetch_busy, fetch_overrun);
    end
    next();
    reset = 1'b1;
    next();
    reset = 1'b0;
    #2;
    n_checks++;
    if (fetch_overrun !== 1'b0) begin
      n_fail++; $display("FAIL ovr_clear: got %b expected 0", fetch_overrun);
    end
  endtask

  task automatic test_reset_mid_burst();
    next();
    line_start = 1'b1; fetch_row = 5'd5;
    for (int k = 1; k <= 15; k++) begin
      next();
      line_start = 1'b0;
      reset = (k == 15);
    end
    next();
    reset = 1'b0;
    #2;
    n_checks++;
    if (fetch_busy !== 1'b0 || lb_we !== 1'b0 || cpu_rdy !== 1'b1 || fetch_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got busy=%b lb_we=%b rdy=%b done=%b expected 0/0/1/0",
               fetch_busy, lb_we, cpu_rdy, fetch_done);
    end
    for (int k = 17; k <= 36; k++) begin
      next();
      #2;
      n_checks++;
      if (fetch_done !== 1'b0 || fetch_busy !== 1'b0 || ram_en !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_quiet k=%0d: got done=%b busy=%b en=%b expected 0/0/0",
                 k, fetch_done, fetch_busy, ram_en);
      end
    end
    next();
    reset = 1'b1; line_start = 1'b1; fetch_row = 5'd1;
    next();
    reset = 1'b0; line_start = 1'b0;
    #2;
    n_checks++;
    if (fetch_busy !== 1'b0 || cpu_rdy !== 1'b1 || ram_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_and_start: got busy=%b rdy=%b en=%b expected 0/1/0",
               fetch_busy, cpu_rdy, ram_en);
    end
    next();
    #2;
    n_checks++;
    if (fetch_busy !== 1'b0 || lb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_and_start_2: got busy=%b lb_we=%b expected 0/0", fetch_busy, lb_we);
    end
  endtask

  task automatic test_wrap();
    next();
    line_start = 1'b1; fetch_row = 5'd0; cpu_req = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      next();
      line_start = 1'b0;
      #2;
      if (k == 16) begin
        n_checks++;
        if (w_ram_addr !== 16'hFFFF) begin
          n_fail++; $display("FAIL wrap_col15: got %h expected ffff", w_ram_addr);
        end
      end
      if (k == 17) begin
        n_checks++;
        if (w_ram_addr !== 16'h0000) begin
          n_fail++; $display("FAIL wrap_col16: got %h expected 0000", w_ram_addr);
        end
      end
      if (k == 32) begin
        n_checks++;
        if (w_ram_addr !== 16'h000F) begin
          n_fail++; $display("FAIL wrap_col31: got %h expected 000f", w_ram_addr);
        end
      end
      if (k == 18) begin
        n_checks++;
        if (w_lb_we !== 1'b1 || w_lb_waddr !== 5'd16 || w_lb_wdata !== 8'h00) begin
          n_fail++;
          $display("FAIL wrap_lb: got we=%b col=%0d data=%h expected 1/16/00",
                   w_lb_we, w_lb_waddr, w_lb_wdata);
        end
      end
      if (k == 33) begin
        n_checks++;
        if (w_fetch_done !== 1'b1 || w_cpu_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL wrap_done: got done=%b rdy=%b expected 1/1", w_fetch_done, w_cpu_rdy);
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a);
    reset = 1'b1; line_start = 1'b0; fetch_row = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    test_reset();
    test_idle_cpu();
    test_row_fetch(5'd3);
    test_overrun();
    test_reset_mid_burst();
    test_row_fetch(5'd2);
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
